// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm fader: FSM encoding, register offsets and
// bit positions of the CPU-visible fields.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    STEP = 2'd2
  } fade_state_t;

  localparam logic PWM_FADE_TARGET = 1'b0;
  localparam logic PWM_FADE_CONFIG = 1'b1;

  localparam int unsigned RDATA_BUSY_BIT = 0;
  localparam int unsigned RDATA_CUR_LSB  = 16;
  localparam int unsigned CFG_PERIOD_LSB = 16;

endpackage

// File: rtl/pwm_fade_timer.sv
// Loadable down-counter pacing the fader's steps; holds at zero until the
// next load.
module pwm_fade_timer #(
  parameter int unsigned PWIDTH = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [PWIDTH-1:0] load_val,
  input  logic              en,
  output logic              zero
);

  logic [PWIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - PWIDTH'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/pwm_fader.sv
// Brightness-ramp controller: walks a pwm channel's duty value toward a
// CPU-programmed target, one registered write strobe per step.
module pwm_fader
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned PWIDTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic        wstrb,
  input  logic        addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        pwm_sel,
  output logic        pwm_wstrb,
  output logic [31:0] pwm_wdata
);

  fade_state_t       state_q, state_d;
  logic [WIDTH-1:0]  tgt_q, cur_q, cur_d, step_q;
  logic [WIDTH-1:0]  cur_step, delta;
  logic [WIDTH:0]    diff;
  logic [PWIDTH-1:0] period_q, tmr_load_val;
  logic [31:0]       pwm_wdata_q;
  logic              up, jump, tgt_wr, cfg_wr;
  logic              strobe_q, strobe_d, busy;
  logic              tmr_load, tmr_en, tmr_zero;
  logic              unused_wdata;

  assign tgt_wr = sel & wstrb & (addr == PWM_FADE_TARGET);
  assign cfg_wr = sel & wstrb & (addr == PWM_FADE_CONFIG);
  assign jump   = (period_q == '0) || (step_q == '0);
  assign unused_wdata = &{1'b0, wdata};

  // One extra bit on the difference keeps the clamp exact at full scale.
  always_comb begin
    up       = (tgt_q > cur_q);
    diff     = up ? ({1'b0, tgt_q} - {1'b0, cur_q})
                  : ({1'b0, cur_q} - {1'b0, tgt_q});
    delta    = (jump || ({1'b0, step_q} >= diff)) ? diff[WIDTH-1:0] : step_q;
    cur_step = up ? (cur_q + delta) : (cur_q - delta);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tgt_q    <= '0;
      step_q   <= WIDTH'(1);
      period_q <= '0;
    end else begin
      if (tgt_wr) begin
        tgt_q <= wdata[WIDTH-1:0];
      end
      if (cfg_wr) begin
        step_q   <= wdata[WIDTH-1:0];
        period_q <= wdata[CFG_PERIOD_LSB +: PWIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      strobe_q    <= 1'b0;
      pwm_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      strobe_q    <= strobe_d;
      pwm_wdata_q <= strobe_d ? 32'(cur_d) : '0;
    end
  end

  // STEP works from the registered target, so a write landing on the same
  // edge only affects the following step.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    strobe_d     = 1'b0;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
    tmr_load_val = period_q - PWIDTH'(1);
    case (state_q)
      IDLE: begin
        if (tgt_wr && (wdata[WIDTH-1:0] != cur_q)) begin
          if (jump) begin
            state_d = STEP;
          end else begin
            state_d  = WAIT;
            tmr_load = 1'b1;
          end
        end
      end
      WAIT: begin
        if (tmr_zero) begin
          state_d = STEP;
        end else begin
          tmr_en = 1'b1;
        end
      end
      STEP: begin
        if (tgt_q == cur_q) begin
          state_d = IDLE;
        end else begin
          cur_d    = cur_step;
          strobe_d = 1'b1;
          if (cur_step == tgt_q) begin
            state_d = IDLE;
          end else begin
            state_d  = WAIT;
            tmr_load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  pwm_fade_timer #(
    .PWIDTH(PWIDTH)
  ) u_timer (
    .clk     (clk),
    .resetn  (resetn),
    .load    (tmr_load),
    .load_val(tmr_load_val),
    .en      (tmr_en),
    .zero    (tmr_zero)
  );

  assign busy = (state_q != IDLE) | strobe_q;

  always_comb begin
    rdata = '0;
    rdata[RDATA_CUR_LSB +: WIDTH] = cur_q;
    rdata[RDATA_BUSY_BIT]         = busy;
  end

  assign pwm_sel   = strobe_q;
  assign pwm_wstrb = strobe_q;
  assign pwm_wdata = pwm_wdata_q;

endmodule
